key_debounce_latch: RTL and testbench

- Sits directly downstream of the keypad scan FSM. Consumes its decoded key code and key-pressed flag.
- Debounces the press and the release, and accepts exactly one event per physical press.
- On each accepted press, shifts the new digit into a two-digit history (new/old) that drives the dual seven-segment display mux.
- Emits a one-cycle strobe for each accepted key.

---
 rtl/key_debounce_latch.sv | 126 ++++++++++++
 tb/tb_key_debounce_latch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_latch.sv
// Debounces the keypad scan FSM output and shifts each accepted digit into a two-digit history.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module key_debounce_latch #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old,
   output logic       key_strobe,
   output logic       key_held
);

   localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       code_reg, code_next;
   logic [3:0]       digit_new_reg, digit_old_reg;
   logic             strobe_reg, held_reg;
   logic             commit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         code_reg      <= 4'h0;
         digit_new_reg <= 4'h0;
         digit_old_reg <= 4'h0;
         strobe_reg    <= 1'b0;
         held_reg      <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         code_reg   <= code_next;
         strobe_reg <= commit;
         // key_held is registered from the next state so it tracks HELD exactly
         held_reg   <= (state_next == HELD);
         if (commit) begin
            digit_old_reg <= digit_new_reg;
            digit_new_reg <= code_reg;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      code_next  = code_reg;
      commit     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (key_valid) begin
               code_next  = key_code;
               cnt_next   = '0;
               state_next = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (key_valid && (key_code == code_reg)) begin
               if (cnt_reg == DEB_LAST) begin
                  commit     = 1'b1;
                  cnt_next   = '0;
                  state_next = HELD;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end else begin
               state_next = IDLE;
            end
         end
         HELD: begin
            if (key_valid) begin
`ifdef KEY_REPEAT_EN
               if (cnt_reg == REP_LAST) begin
                  commit   = 1'b1;
                  cnt_next = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
`endif
            end else begin
               cnt_next   = '0;
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            // a brief return of key_valid is treated as bounce, not a new press
            if (key_valid) begin
               cnt_next   = '0;
               state_next = HELD;
            end else if (cnt_reg == DEB_LAST) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign digit_new  = digit_new_reg;
   assign digit_old  = digit_old_reg;
   assign key_strobe = strobe_reg;
   assign key_held   = held_reg;

endmodule

// File: tb/tb_key_debounce_latch.sv
// Scoreboard bench for key_debounce_latch with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Stimulus pushes each expected strobe (cycle, digits); a monitor pops and compares on every strobe.
module tb_key_debounce_latch;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_code;
   logic       key_valid;
   logic [3:0] digit_new, digit_old;
   logic       key_strobe, key_held;

   typedef struct {
      int         cyc;
      logic [3:0] dnew;
      logic [3:0] dold;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_strobe = 1'b0;

   key_debounce_latch #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
      .digit_new(digit_new), .digit_old(digit_old),
      .key_strobe(key_strobe), .key_held(key_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (!reset && key_strobe) begin
         exp_t e;
         checks++;
         if (prev_strobe) begin
            errors++;
            $display("FAIL strobe_width: strobe high two cycles at cyc %0d", cyc);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: cyc %0d digits %h/%h, none required", cyc, digit_new, digit_old);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.dnew != digit_new || e.dold != digit_old) begin
               errors++;
               $display("FAIL strobe: got cyc %0d digits %h/%h, required cyc %0d digits %h/%h",
                        cyc, digit_new, digit_old, e.cyc, e.dnew, e.dold);
            end else begin
               $display("strobe ok: cyc %0d digit_new %h digit_old %h", cyc, digit_new, digit_old);
            end
         end
      end
      prev_strobe = key_strobe;
   end

   task automatic step(input logic v, input logic [3:0] c);
      @(negedge clk);
      key_valid = v;
      key_code  = c;
   endtask

   // Expect a strobe on the edge that samples the value just driven
   task automatic expect_strobe(input logic [3:0] dn, input logic [3:0] dold);
      exp_t e;
      e.cyc  = cyc + 1;
      e.dnew = dn;
      e.dold = dold;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end else begin
         $display("check ok: %s = %h", name, act);
      end
   endtask

   // Five matching samples (IDLE capture + 4 debounce) accept the key
   task automatic press(input logic [3:0] c, input logic [3:0] dn, input logic [3:0] dold);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, c);
         if (i == 4) expect_strobe(dn, dold);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0);
   endtask

   initial begin
      reset = 1'b1;
      key_valid = 1'b0;
      key_code = 4'h0;
      repeat (3) @(negedge clk);
      check("reset_digit_new", digit_new, 4'h0);
      check("reset_digit_old", digit_old, 4'h0);
      check("reset_strobe", {3'b0, key_strobe}, 4'h0);
      check("reset_held", {3'b0, key_held}, 4'h0);
      reset = 1'b0;
      idle(3);

`ifdef KEY_REPEAT_EN
      // Auto-repeat: one press strobe then repeats every 10 cycles of hold
      press(4'h6, 4'h6, 4'h0);
      for (int i = 0; i < 35; i++) begin
         step(1'b1, 4'h6);
         if (i == 9 || i == 19 || i == 29) expect_strobe(4'h6, 4'h6);
      end
      check("rep_held", {3'b0, key_held}, 4'h1);
      idle(8);
      check("rep_digit_new", digit_new, 4'h6);
      check("rep_digit_old", digit_old, 4'h6);
      check("rep_held_after", {3'b0, key_held}, 4'h0);
`else
      // Single press of 0x7, held 20, released 10
      press(4'h7, 4'h7, 4'h0);
      for (int i = 0; i < 20; i++) step(1'b1, 4'h7);
      check("p7_held", {3'b0, key_held}, 4'h1);
      idle(10);
      check("p7_held_after", {3'b0, key_held}, 4'h0);
      check("p7_digit_new", digit_new, 4'h7);
      check("p7_digit_old", digit_old, 4'h0);

      // Two presses shift the history
      press(4'h3, 4'h3, 4'h7);
      for (int i = 0; i < 3; i++) step(1'b1, 4'h3);
      idle(8);
      press(4'hA, 4'hA, 4'h3);
      for (int i = 0; i < 3; i++) step(1'b1, 4'hA);
      idle(8);
      check("two_digit_new", digit_new, 4'hA);
      check("two_digit_old", digit_old, 4'h3);

      // Press bounce and code change mid-debounce: no strobe
      for (int i = 0; i < 3; i++) step(1'b1, 4'h2);
      step(1'b0, 4'h2);
      for (int i = 0; i < 3; i++) step(1'b1, 4'h2);
      idle(3);
      step(1'b1, 4'h2); step(1'b1, 4'h2);
      step(1'b1, 4'h4); step(1'b1, 4'h4); step(1'b1, 4'h4);
      idle(4);
      check("bounce_digit_new", digit_new, 4'hA);
      check("bounce_digit_old", digit_old, 4'h3);

      // Release glitch keeps HELD; code change while held is ignored
      press(4'h9, 4'h9, 4'hA);
      for (int i = 0; i < 3; i++) step(1'b1, 4'h9);
      idle(2);
      for (int i = 0; i < 3; i++) step(1'b1, 4'h9);
      check("glitch_held", {3'b0, key_held}, 4'h1);
      for (int i = 0; i < 8; i++) step(1'b1, 4'h1);
      check("held_change_held", {3'b0, key_held}, 4'h1);
      idle(8);
      check("glitch_held_after", {3'b0, key_held}, 4'h0);
      check("glitch_digit_new", digit_new, 4'h9);
      check("glitch_digit_old", digit_old, 4'hA);
`endif

      // Asynchronous reset mid-debounce clears digits without a strobe
      step(1'b1, 4'h5); step(1'b1, 4'h5);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("areset_digit_new", digit_new, 4'h0);
      check("areset_digit_old", digit_old, 4'h0);
      check("areset_strobe", {3'b0, key_strobe}, 4'h0);
      check("areset_held", {3'b0, key_held}, 4'h0);
      @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      idle(10);
      check("post_reset_digit_new", digit_new, 4'h0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_strobes: %0d outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
